hand_axis_ctrl: RTL
===================

HAND_AXIS_CTRL -- requirements
Module: hand_axis_ctrl

Interface
REQ-001 Parameter COORD_W, default 16, meaning hand coordinate width.
REQ-002 Parameter CMD_W, default 8, meaning command width.
REQ-003 Parameter NEUTRAL, default 116, meaning centred command.
REQ-004 Parameter MIN_CMD, default 68, meaning lower command clamp.
REQ-005 Parameter MAX_CMD, default 184, meaning upper command clamp.
REQ-006 Parameter DEADBAND, default 38, meaning minimum |pos_a-pos_b| that produces motion.
REQ-007 Parameter GAIN_SHIFT, default 1, meaning right-shift applied to (diff-DEADBAND).
REQ-008 Parameter POS_LIMIT, default 512, meaning a coordinate above this is invalid.
REQ-009 Parameter SLEW_STEP, default 4, meaning maximum command change per slew tick.
REQ-010 Parameter SLEW_DIV, default 1, meaning clock cycles per slew tick.
REQ-011 Parameter LOST_TIMEOUT, default 1024, meaning invalid-sample cycles before returning to neutral.
REQ-012 clock  in  1  single clock; all state on rising edge.
REQ-013 reset_n  in  1  reset; asynchronous, active-low.
REQ-014 sample_valid  in  1  one-cycle strobe qualifying pos_a/pos_b.
REQ-015 pos_a  in  COORD_W  left-hand coordinate; 0 means not detected.
REQ-016 pos_b  in  COORD_W  right-hand coordinate; 0 means not detected.
REQ-017 cmd  out  CMD_W  registered axis command.
REQ-018 direction  out  2  registered direction: 0 NONE, 1 NEG (LEFT), 2 POS (RIGHT).
REQ-019 tracking_lost  out  1  high while in RETURN or IDLE after a timeout.

Function
REQ-020 diff SHALL be |pos_a-pos_b|, computed COORD_W+1 bits unsigned.
REQ-021 Sample invalid SHALL mean pos_a==0, pos_b==0, pos_a>POS_LIMIT or pos_b>POS_LIMIT.
REQ-022 Valid sample, diff<DEADBAND or pos_a==pos_b: target=NEUTRAL, direction=NONE.
REQ-023 Otherwise, if pos_a>pos_b: target=NEUTRAL-((diff-DEADBAND)>>GAIN_SHIFT), direction=POS; if pos_b>pos_a: target=NEUTRAL+offset, direction=NEG.
REQ-024 Target arithmetic SHALL be signed, at least CMD_W+COORD_W bits wide, and clamped to [MIN_CMD,MAX_CMD] before truncation to CMD_W.
REQ-025 target and direction SHALL register one cycle after a sample_valid edge; with no sample_valid, target holds.
REQ-026 FSM states: IDLE, TRACK, HOLD, RETURN.
REQ-027 IDLE->TRACK on a valid sample; TRACK->HOLD on an invalid sample; HOLD->TRACK on a valid sample.
REQ-028 HOLD SHALL count cycles; when the count reaches LOST_TIMEOUT, go to RETURN and set target=NEUTRAL, direction=NONE.
REQ-029 RETURN->IDLE when cmd==NEUTRAL; RETURN->TRACK on a valid sample, which takes priority over reaching neutral in the same cycle.
REQ-030 On each slew tick, cmd SHALL move toward target by min(SLEW_STEP, |target-cmd|) and never overshoot.
REQ-031 A new target mid-ramp SHALL redirect the ramp from the current cmd on the next tick.
REQ-032 tracking_lost SHALL set on HOLD->RETURN and clear on the next valid sample.

Reset
REQ-033 While reset_n is low: cmd=NEUTRAL, target=NEUTRAL, direction=NONE, tracking_lost=0, state=IDLE, all counters 0; this applies at any time, including mid-ramp.

Configuration
REQ-034 Macro HAND_AXIS_SLEW_EN defined: slew limiting per REQ-030/031 is active.
REQ-035 Macro HAND_AXIS_SLEW_EN undefined: cmd=target one cycle after target updates (two cycles after sample_valid), and RETURN completes in one cycle.

Structure
REQ-036 Package hand_ctrl_pkg SHALL hold the direction encoding (NONE/NEG/POS) and the FSM state encoding.
REQ-037 Slew limiting SHALL be a sub-module, axis_slew_limiter (inputs target/tick, output cmd), instantiated only under HAND_AXIS_SLEW_EN.

Verification
REQ-038 Slew off, pos_a=300, pos_b=200 -> target 85, direction=POS, cmd=85 two cycles after the strobe.
REQ-039 pos_a=100, pos_b=200 -> cmd 147, direction=NEG; pos_a=100, pos_b=137 (diff 37) -> cmd 116, direction=NONE.
REQ-040 pos_a=700, pos_b=100 -> invalid -> HOLD; pos_a=600, pos_b=100 with POS_LIMIT=1023 -> clamp to 68.
REQ-041 Slew on (STEP 4, DIV 1), target 184 from 116 -> 17 ticks of +4; cmd never exceeds 184.
REQ-042 pos_b=0 for LOST_TIMEOUT cycles -> tracking_lost=1, cmd ramps to 116, state IDLE; a valid sample during the ramp returns to TRACK.
REQ-043 reset_n pulsed low mid-ramp at cmd=150 -> cmd=116 immediately, asynchronously, before the next clock edge.

Source files
------------

// File: rtl/hand_axis_ctrl_pkg.sv
// Shared encodings for the hand axis controller: direction codes and controller FSM states.
package hand_ctrl_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        NEG  = 2'd1,
        POS  = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        HOLD   = 2'd2,
        RETURN = 2'd3
    } state_t;

endpackage

// File: rtl/hand_axis_ctrl_if.sv
// Sample/command bundle between a hand tracker (master) and the axis controller (slave).
interface hand_axis_ctrl_if
    import hand_ctrl_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int CMD_W   = 8
);

    logic               sample_valid;
    logic [COORD_W-1:0] pos_a;
    logic [COORD_W-1:0] pos_b;
    logic [CMD_W-1:0]   cmd;
    dir_t               direction;
    logic               tracking_lost;

    modport master (
        output sample_valid, pos_a, pos_b,
        input  cmd, direction, tracking_lost
    );

    modport slave (
        input  sample_valid, pos_a, pos_b,
        output cmd, direction, tracking_lost
    );

endinterface

// File: rtl/hand_axis_ctrl_slew.sv
// axis_slew_limiter: walks cmd toward target by at most SLEW_STEP per tick, landing exactly on target.
module axis_slew_limiter #(
    parameter int CMD_W     = 8,
    parameter int NEUTRAL   = 116,
    parameter int SLEW_STEP = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CMD_W-1:0] target,
    input  logic             tick,
    output logic [CMD_W-1:0] cmd
);

    localparam logic [CMD_W-1:0] STEP = CMD_W'(SLEW_STEP);

    logic [CMD_W-1:0] gap;

    always_comb begin
        gap = (target > cmd) ? (target - cmd) : (cmd - target);
    end

    // A remaining gap no larger than one step snaps to target, so the ramp never overshoots
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd <= CMD_W'(NEUTRAL);
        end else if (tick && (gap != '0)) begin
            if (gap <= STEP) begin
                cmd <= target;
            end else if (target > cmd) begin
                cmd <= cmd + STEP;
            end else begin
                cmd <= cmd - STEP;
            end
        end
    end

endmodule

// File: rtl/hand_axis_ctrl.sv
// Hand-gesture axis controller: two hand coordinates -> clamped target, direction and axis command.
// Build macro HAND_AXIS_SLEW_EN inserts axis_slew_limiter; without it cmd follows target one cycle later.
module hand_axis_ctrl
    import hand_ctrl_pkg::*;
#(
    parameter int COORD_W      = 16,
    parameter int CMD_W        = 8,
    parameter int NEUTRAL      = 116,
    parameter int MIN_CMD      = 68,
    parameter int MAX_CMD      = 184,
    parameter int DEADBAND     = 38,
    parameter int GAIN_SHIFT   = 1,
    parameter int POS_LIMIT    = 512,
    parameter int SLEW_STEP    = 4,
    parameter int SLEW_DIV     = 1,
    parameter int LOST_TIMEOUT = 1024
) (
    input logic             clock,
    input logic             reset_n,
    hand_axis_ctrl_if.slave axis
);

    localparam int W     = CMD_W + COORD_W + 2;
    localparam int CNT_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(LOST_TIMEOUT - 1);
    localparam logic signed [W-1:0] NEUTRAL_S = W'(NEUTRAL);
    localparam logic signed [W-1:0] MIN_S     = W'(MIN_CMD);
    localparam logic signed [W-1:0] MAX_S     = W'(MAX_CMD);
    localparam logic signed [W-1:0] DEAD_S    = W'(DEADBAND);
    localparam logic [W-1:0]        DEAD_U    = W'(DEADBAND);
    localparam logic [W-1:0]        LIMIT_U   = W'(POS_LIMIT);
    localparam logic [CMD_W-1:0]    NEUTRAL_C = CMD_W'(NEUTRAL);
    localparam logic [CMD_W-1:0]    MIN_C     = CMD_W'(MIN_CMD);
    localparam logic [CMD_W-1:0]    MAX_C     = CMD_W'(MAX_CMD);

    if ((SLEW_STEP < 1) || (SLEW_DIV < 1) || (MIN_CMD > MAX_CMD) || (LOST_TIMEOUT < 1)) begin : g_bad_param
        $error("hand_axis_ctrl: inconsistent parameters");
    end

    state_t             state, state_next;
    logic [CMD_W-1:0]   target, cmd_q, calc_target;
    dir_t               direction, calc_dir;
    logic               lost;
    logic [CNT_W-1:0]   hold_cnt;
    logic [COORD_W:0]   diff;
    logic               a_gt_b, invalid, good, timeout;
    logic               load_sample, go_return, count_en;
    logic signed [W-1:0] offset, raw;

    // Sample evaluation: deadband, gain and clamp in a signed width that cannot wrap
    always_comb begin
        a_gt_b  = axis.pos_a > axis.pos_b;
        diff    = a_gt_b ? ({1'b0, axis.pos_a} - {1'b0, axis.pos_b})
                         : ({1'b0, axis.pos_b} - {1'b0, axis.pos_a});
        invalid = (axis.pos_a == '0) || (axis.pos_b == '0) ||
                  (W'(axis.pos_a) > LIMIT_U) || (W'(axis.pos_b) > LIMIT_U);
        good    = axis.sample_valid && !invalid;
        timeout = hold_cnt == CNT_LAST;
        offset  = ($signed(W'(diff)) - DEAD_S) >>> GAIN_SHIFT;
        raw      = NEUTRAL_S;
        calc_dir = NONE;
        if ((W'(diff) >= DEAD_U) && (axis.pos_a != axis.pos_b)) begin
            if (a_gt_b) begin
                raw      = NEUTRAL_S - offset;
                calc_dir = POS;
            end else begin
                raw      = NEUTRAL_S + offset;
                calc_dir = NEG;
            end
        end
        if (raw < MIN_S) begin
            calc_target = MIN_C;
        end else if (raw > MAX_S) begin
            calc_target = MAX_C;
        end else begin
            calc_target = raw[CMD_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A valid sample wins over every other exit, including reaching neutral while returning
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (good) state_next = TRACK;
            TRACK:   if (axis.sample_valid && invalid) state_next = HOLD;
            HOLD:    if (good) state_next = TRACK;
                     else if (timeout) state_next = RETURN;
            RETURN:  if (good) state_next = TRACK;
                     else if (cmd_q == NEUTRAL_C) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_sample = good;
        go_return   = (state == HOLD) && !good && timeout;
        count_en    = (state == HOLD) && !good && !timeout;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            target    <= NEUTRAL_C;
            direction <= NONE;
            lost      <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            if (load_sample) begin
                target    <= calc_target;
                direction <= calc_dir;
                lost      <= 1'b0;
            end else if (go_return) begin
                target    <= NEUTRAL_C;
                direction <= NONE;
                lost      <= 1'b1;
            end
            hold_cnt <= count_en ? hold_cnt + 1'b1 : '0;
        end
    end

`ifdef HAND_AXIS_SLEW_EN
    localparam int DIV_W = $clog2(SLEW_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_comb begin
        tick = div_cnt == DIV_W'(SLEW_DIV - 1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    axis_slew_limiter #(
        .CMD_W     (CMD_W),
        .NEUTRAL   (NEUTRAL),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clock   (clock),
        .reset_n (reset_n),
        .target  (target),
        .tick    (tick),
        .cmd     (cmd_q)
    );
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q <= NEUTRAL_C;
        end else begin
            cmd_q <= target;
        end
    end
`endif

    assign axis.cmd           = cmd_q;
    assign axis.direction     = direction;
    assign axis.tracking_lost = lost;

endmodule
